// File: rtl/reg_file_scb_if.sv
// Register-file bus: two read ports with scoreboard status, one write port, one reserve port.
interface reg_file_scb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] RF_rd_addr1;
    logic [ADDR_W-1:0] RF_rd_addr2;
    logic              RF_rd_en;
    logic [DATA_W-1:0] RF_rd_data1;
    logic [DATA_W-1:0] RF_rd_data2;
    logic              RF_busy1;
    logic              RF_busy2;
    logic              RF_rd_valid;
    logic              RF_wr_en;
    logic [ADDR_W-1:0] RF_wr_addr;
    logic [DATA_W-1:0] RF_wr_data;
    logic              RF_rsv_en;
    logic [ADDR_W-1:0] RF_rsv_addr;

    modport master (
        output RF_rd_addr1, RF_rd_addr2, RF_rd_en,
        output RF_wr_en, RF_wr_addr, RF_wr_data,
        output RF_rsv_en, RF_rsv_addr,
        input  RF_rd_data1, RF_rd_data2, RF_busy1, RF_busy2, RF_rd_valid
    );

    modport slave (
        input  RF_rd_addr1, RF_rd_addr2, RF_rd_en,
        input  RF_wr_en, RF_wr_addr, RF_wr_data,
        input  RF_rsv_en, RF_rsv_addr,
        output RF_rd_data1, RF_rd_data2, RF_busy1, RF_busy2, RF_rd_valid
    );
endinterface

// File: rtl/reg_file_scb.sv
// Two-read/one-write register file with a per-register pending scoreboard.
// Reads are registered, write-first; busy reflects the same-cycle write clear only.
module reg_file_scb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input logic           RF_clk,
    input logic           RF_rst,
    reg_file_scb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [DEPTH-1:0]  pend_clr_s;
    logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;
    logic              busy1_q, busy1_d;
    logic              busy2_q, busy2_d;
    logic              valid_q, valid_d;
    logic              wr_ok_s;
    logic              rsv_ok_s;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG == 1'b1) && (addr == {ADDR_W{1'b0}});
    endfunction

    // Next-state for storage, scoreboard and read outputs (write-first bypass via mem_d).
    always_comb begin
        wr_ok_s  = bus.RF_wr_en && !is_zero_reg(bus.RF_wr_addr);
        rsv_ok_s = bus.RF_rsv_en && !is_zero_reg(bus.RF_rsv_addr);

        mem_d      = mem_q;
        pend_clr_s = pend_q;
        if (wr_ok_s) begin
            mem_d[bus.RF_wr_addr]      = bus.RF_wr_data;
            pend_clr_s[bus.RF_wr_addr] = 1'b0;
        end else begin
            pend_clr_s = pend_q;
        end

        // Reserve is applied after the clear so a new producer wins.
        pend_d = pend_clr_s;
        if (rsv_ok_s) begin
            pend_d[bus.RF_rsv_addr] = 1'b1;
        end else begin
            pend_d = pend_clr_s;
        end

        rd_data1_d = rd_data1_q;
        rd_data2_d = rd_data2_q;
        busy1_d    = busy1_q;
        busy2_d    = busy2_q;
        if (bus.RF_rd_en) begin
            rd_data1_d = mem_d[bus.RF_rd_addr1];
            rd_data2_d = mem_d[bus.RF_rd_addr2];
            busy1_d    = pend_clr_s[bus.RF_rd_addr1];
            busy2_d    = pend_clr_s[bus.RF_rd_addr2];
        end else begin
            rd_data1_d = rd_data1_q;
            rd_data2_d = rd_data2_q;
        end
        valid_d = bus.RF_rd_en;
    end

    // State registers with asynchronous clear of contents, scoreboard and outputs.
    always_ff @(posedge RF_clk or posedge RF_rst) begin
        if (RF_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            pend_q     <= {DEPTH{1'b0}};
            rd_data1_q <= {DATA_W{1'b0}};
            rd_data2_q <= {DATA_W{1'b0}};
            busy1_q    <= 1'b0;
            busy2_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            pend_q     <= pend_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
            busy1_q    <= busy1_d;
            busy2_q    <= busy2_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.RF_rd_data1 = rd_data1_q;
    assign bus.RF_rd_data2 = rd_data2_q;
    assign bus.RF_busy1    = busy1_q;
    assign bus.RF_busy2    = busy2_q;
    assign bus.RF_rd_valid = valid_q;
endmodule

// File: tb/tb_reg_file_scb.sv
// Bench for reg_file_scb: one ZERO_REG=1 and one ZERO_REG=0 instance share stimulus
// and are compared every cycle against an array-based scoreboard model.
module tb_reg_file_scb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 2 ** AW;

    logic clk = 1'b0;
    logic rst;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file_scb_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
    reg_file_scb_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

    reg_file_scb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut_a (
        .RF_clk(clk), .RF_rst(rst), .bus(ifa.slave));
    reg_file_scb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) dut_b (
        .RF_clk(clk), .RF_rst(rst), .bus(ifb.slave));

    assign ifb.RF_rd_addr1 = ifa.RF_rd_addr1;
    assign ifb.RF_rd_addr2 = ifa.RF_rd_addr2;
    assign ifb.RF_rd_en    = ifa.RF_rd_en;
    assign ifb.RF_wr_en    = ifa.RF_wr_en;
    assign ifb.RF_wr_addr  = ifa.RF_wr_addr;
    assign ifb.RF_wr_data  = ifa.RF_wr_data;
    assign ifb.RF_rsv_en   = ifa.RF_rsv_en;
    assign ifb.RF_rsv_addr = ifa.RF_rsv_addr;

    // Model: index 0 = ZERO_REG=1 instance, index 1 = ZERO_REG=0 instance.
    logic [DW-1:0] m_mem  [2][N];
    logic          m_pend [2][N];
    logic [DW-1:0] e_d1 [2];
    logic [DW-1:0] e_d2 [2];
    logic          e_b1 [2];
    logic          e_b2 [2];
    logic          e_v;

    function automatic logic ign(input int k, input logic [AW-1:0] a);
        return (k == 0) && (a == 5'd0);
    endfunction

    function automatic logic [DW-1:0] m_data(input int k, input logic [AW-1:0] a);
        if (ign(k, a)) return 32'd0;
        if (ifa.RF_wr_en && ifa.RF_wr_addr == a) return ifa.RF_wr_data;
        return m_mem[k][a];
    endfunction

    function automatic logic m_busy(input int k, input logic [AW-1:0] a);
        if (ign(k, a)) return 1'b0;
        if (ifa.RF_wr_en && ifa.RF_wr_addr == a) return 1'b0;
        return m_pend[k][a];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                m_mem[k][i]  = 32'd0;
                m_pend[k][i] = 1'b0;
            end
            e_d1[k] = 32'd0; e_d2[k] = 32'd0; e_b1[k] = 1'b0; e_b2[k] = 1'b0;
        end
        e_v = 1'b0;
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (ifa.RF_rd_en) begin
                e_d1[k] = m_data(k, ifa.RF_rd_addr1);
                e_d2[k] = m_data(k, ifa.RF_rd_addr2);
                e_b1[k] = m_busy(k, ifa.RF_rd_addr1);
                e_b2[k] = m_busy(k, ifa.RF_rd_addr2);
            end
            if (ifa.RF_wr_en && !ign(k, ifa.RF_wr_addr)) begin
                m_mem[k][ifa.RF_wr_addr]  = ifa.RF_wr_data;
                m_pend[k][ifa.RF_wr_addr] = 1'b0;
            end
            if (ifa.RF_rsv_en && !ign(k, ifa.RF_rsv_addr))
                m_pend[k][ifa.RF_rsv_addr] = 1'b1;
        end
        e_v = ifa.RF_rd_en;
    endtask

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_data1", ifa.RF_rd_data1, e_d1[0]);
            check("a_data2", ifa.RF_rd_data2, e_d2[0]);
            check("a_busy1", 32'(ifa.RF_busy1), 32'(e_b1[0]));
            check("a_busy2", 32'(ifa.RF_busy2), 32'(e_b2[0]));
            check("a_valid", 32'(ifa.RF_rd_valid), 32'(e_v));
            check("b_data1", ifb.RF_rd_data1, e_d1[1]);
            check("b_data2", ifb.RF_rd_data2, e_d2[1]);
            check("b_busy1", 32'(ifb.RF_busy1), 32'(e_b1[1]));
            check("b_busy2", 32'(ifb.RF_busy2), 32'(e_b2[1]));
            check("b_valid", 32'(ifb.RF_rd_valid), 32'(e_v));
        end
    end

    task automatic set_in(input logic re, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic rs, input logic [AW-1:0] ra);
        ifa.RF_rd_en = re; ifa.RF_rd_addr1 = a1; ifa.RF_rd_addr2 = a2;
        ifa.RF_wr_en = we; ifa.RF_wr_addr = wa; ifa.RF_wr_data = wd;
        ifa.RF_rsv_en = rs; ifa.RF_rsv_addr = ra;
    endtask

    task automatic drive(input logic re, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rs, input logic [AW-1:0] ra);
        set_in(re, a1, a2, we, wa, wd, rs, ra);
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    function automatic logic [AW-1:0] raddr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom);
    endfunction

    task automatic rand_cycle();
        drive(1'($urandom_range(0, 2) != 0), raddr(), raddr(),
              1'($urandom_range(0, 1)), raddr(), $urandom,
              1'($urandom_range(0, 3) == 0), raddr());
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        model_reset();
        cmp_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data1", ifa.RF_rd_data1, 32'd0);
        check("rst_valid", 32'(ifa.RF_rd_valid), 32'd0);
        rst = 1'b0;

        // Write then read r5.
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check("r5_data1", ifa.RF_rd_data1, 32'hDEADBEEF);
        check("r5_valid", 32'(ifa.RF_rd_valid), 32'd1);
        drive(1'b0, 5'd1, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check("hold_data1", ifa.RF_rd_data1, 32'hDEADBEEF);
        check("idle_valid", 32'(ifa.RF_rd_valid), 32'd0);

        // Same-cycle write/read bypass on both ports.
        drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
        check("byp_data1", ifa.RF_rd_data1, 32'h12345678);
        check("byp_data2", ifa.RF_rd_data2, 32'h12345678);

        // Reserve r9, read busy, then write+read clears busy.
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        drive(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check("r9_busy", 32'(ifa.RF_busy1), 32'd1);
        drive(1'b1, 5'd9, 5'd0, 1'b1, 5'd9, 32'h5, 1'b0, 5'd0);
        check("r9_busy_clr", 32'(ifa.RF_busy1), 32'd0);
        check("r9_data", ifa.RF_rd_data1, 32'h5);

        // Reserve and write r3 in one cycle: data lands, bit stays set.
        drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3);
        drive(1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check("r3_data", ifa.RF_rd_data1, 32'hA);
        check("r3_busy1", 32'(ifa.RF_busy1), 32'd1);
        check("r3_busy2", 32'(ifa.RF_busy2), 32'd1);

        // Register 0: hardwired on dut_a, ordinary on dut_b.
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
        check("z_byp_data", ifa.RF_rd_data1, 32'd0);
        check("nz_byp_data", ifb.RF_rd_data1, 32'hFFFFFFFF);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check("z_data", ifa.RF_rd_data1, 32'd0);
        check("z_busy", 32'(ifa.RF_busy1), 32'd0);
        check("nz_busy", 32'(ifb.RF_busy1), 32'd1);

        for (int i = 0; i < 1500; i++) rand_cycle();

        // Load r1..r4, reserve r2, then reset mid-cycle with a write in flight.
        for (int i = 1; i <= 4; i++)
            drive(1'b0, 5'd0, 5'd0, 1'b1, AW'(i), 32'h100 + 32'(i), 1'b0, 5'd0);
        drive(1'b1, 5'd2, 5'd1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2);
        drive(1'b1, 5'd2, 5'd1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check("pre_rst_busy", 32'(ifa.RF_busy1), 32'd1);
        check("pre_rst_data2", ifa.RF_rd_data2, 32'h101);
        set_in(1'b1, 5'd1, 5'd2, 1'b1, 5'd1, 32'h77, 1'b1, 5'd4);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_data2", ifa.RF_rd_data2, 32'd0);
        check("async_busy1", 32'(ifa.RF_busy1), 32'd0);
        check("async_valid", 32'(ifa.RF_rd_valid), 32'd0);
        rand_cycle();
        rst = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check("post_r1", ifa.RF_rd_data1, 32'd0);
        check("post_r2_busy", 32'(ifa.RF_busy2), 32'd0);
        drive(1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        check("post_r3", ifa.RF_rd_data1, 32'd0);
        check("post_r4", ifa.RF_rd_data2, 32'd0);

        for (int i = 0; i < 500; i++) rand_cycle();

        @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
